pe_mem_arbiter: RTL and testbench

//  Shares one Avalon-MM SDRAM master port between the PE array's three DMA masters:

---
 rtl/pe_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_pe_mem_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mem_arbiter.sv
// Shares one Avalon-MM memory master between the input/weight read streams and the output write stream.
// Writes win outright; the two read streams alternate; a tag FIFO steers read data back to its issuer.
module pe_mem_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_read,
   input  logic [ADDR_W-1:0]                  in_address,
   output logic                               in_waitrequest,
   output logic [DATA_W-1:0]                  in_readdata,
   output logic                               in_readdatavalid,
   input  logic                               wt_read,
   input  logic [ADDR_W-1:0]                  wt_address,
   output logic                               wt_waitrequest,
   output logic [DATA_W-1:0]                  wt_readdata,
   output logic                               wt_readdatavalid,
   input  logic                               out_write,
   input  logic [ADDR_W-1:0]                  out_address,
   input  logic [DATA_W-1:0]                  out_writedata,
   output logic                               out_waitrequest,
   output logic                               m_read,
   output logic                               m_write,
   output logic [ADDR_W-1:0]                  m_address,
   output logic [DATA_W-1:0]                  m_writedata,
   input  logic                               m_waitrequest,
   input  logic [DATA_W-1:0]                  m_readdata,
   input  logic                               m_readdatavalid,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               err_orphan
);
   // state  | meaning
   // IDLE   | arbitrate; the winner is accepted this cycle
   // ISSUE  | m_* command held until m_waitrequest drops
   localparam int TAG_AW = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W  = TAG_AW + 1;

   typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_m_read, r_m_write, r_rr_last, r_issue_tag;
   logic [ADDR_W-1:0]     r_m_address;
   logic [DATA_W-1:0]     r_m_writedata;
   logic [MAX_OUTSTANDING-1:0] r_tags;
   logic [TAG_AW-1:0]     r_wptr, r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_W-1:0]     r_in_rdata, r_wt_rdata;
   logic                  r_in_rvalid, r_wt_rvalid, r_err;
   logic                  w_arb, w_fifo_full, w_rd_ok;
   logic                  w_gnt_wr, w_gnt_in, w_gnt_wt;
   logic                  w_push, w_pop, w_pop_tag;

   // rst_n gating keeps every waitrequest high while reset is held
   assign w_arb       = (r_state == ST_IDLE) && rst_n;
   assign w_fifo_full = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_rd_ok     = w_arb && !out_write && !w_fifo_full;
   assign w_gnt_wr    = w_arb && out_write;
   // r_rr_last: 0 = input stream, 1 = weight stream
   assign w_gnt_in    = w_rd_ok && in_read && (!wt_read || r_rr_last);
   assign w_gnt_wt    = w_rd_ok && wt_read && (!in_read || !r_rr_last);

   assign w_push    = r_m_read && !m_waitrequest;
   assign w_pop     = m_readdatavalid && (r_count != '0);
   assign w_pop_tag = r_tags[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_gnt_wr || w_gnt_in || w_gnt_wt) w_state_nxt = ST_ISSUE;
         ST_ISSUE: if (!m_waitrequest) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_read      <= 1'b0;
         r_m_write     <= 1'b0;
         r_m_address   <= '0;
         r_m_writedata <= '0;
         r_rr_last     <= 1'b1;
         r_issue_tag   <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (w_gnt_wr) begin
            r_m_address   <= out_address;
            r_m_writedata <= out_writedata;
            r_m_write     <= 1'b1;
         end else if (w_gnt_in) begin
            r_m_address <= in_address;
            r_m_read    <= 1'b1;
            r_rr_last   <= 1'b0;
            r_issue_tag <= 1'b0;
         end else if (w_gnt_wt) begin
            r_m_address <= wt_address;
            r_m_read    <= 1'b1;
            r_rr_last   <= 1'b1;
            r_issue_tag <= 1'b1;
         end
      end else if (!m_waitrequest) begin
         r_m_read  <= 1'b0;
         r_m_write <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tags      <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_in_rdata  <= '0;
         r_wt_rdata  <= '0;
         r_in_rvalid <= 1'b0;
         r_wt_rvalid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_push) begin
            r_tags[r_wptr] <= r_issue_tag;
            r_wptr         <= r_wptr + TAG_AW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + TAG_AW'(1);
         r_count     <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         r_in_rvalid <= w_pop && !w_pop_tag;
         r_wt_rvalid <= w_pop && w_pop_tag;
         if (w_pop && !w_pop_tag) r_in_rdata <= m_readdata;
         if (w_pop && w_pop_tag)  r_wt_rdata <= m_readdata;
         // data with nothing in flight (including after a mid-read reset) is dropped
         if (m_readdatavalid && (r_count == '0)) r_err <= 1'b1;
      end
   end

   assign in_waitrequest   = !w_gnt_in;
   assign wt_waitrequest   = !w_gnt_wt;
   assign out_waitrequest  = !w_gnt_wr;
   assign m_read           = r_m_read;
   assign m_write          = r_m_write;
   assign m_address        = r_m_address;
   assign m_writedata      = r_m_writedata;
   assign in_readdata      = r_in_rdata;
   assign in_readdatavalid = r_in_rvalid;
   assign wt_readdata      = r_wt_rdata;
   assign wt_readdatavalid = r_wt_rvalid;
   assign outstanding      = r_count;
   assign err_orphan       = r_err;
endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Self-checking bench for pe_mem_arbiter: cycle-level requesters and memory model at the falling edge,
// with per-stream scoreboards of expected read data and a queue of expected writes.
module tb_pe_mem_arbiter;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_read, wt_read, out_write;
   logic [31:0] in_address, wt_address, out_address, out_writedata;
   logic        in_waitrequest, wt_waitrequest, out_waitrequest;
   logic [31:0] in_readdata, wt_readdata;
   logic        in_readdatavalid, wt_readdatavalid;
   logic        m_read, m_write, m_waitrequest, m_readdatavalid;
   logic [31:0] m_address, m_writedata, m_readdata;
   logic [3:0]  outstanding;
   logic        err_orphan;

   typedef struct { int due; logic [31:0] addr; } mreq_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } wreq_t;

   logic [31:0] in_pend[$], wt_pend[$], exp_in_q[$], exp_wt_q[$];
   wreq_t       out_pend[$], exp_wr_q[$];
   mreq_t       mem_q[$];
   int          grant_log[$];
   int          cyc = 0, n_err = 0, n_checks = 0, n_in_rdv = 0;
   bit          auto_resp = 1'b1;

   pe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_read(in_read), .in_address(in_address), .in_waitrequest(in_waitrequest),
      .in_readdata(in_readdata), .in_readdatavalid(in_readdatavalid),
      .wt_read(wt_read), .wt_address(wt_address), .wt_waitrequest(wt_waitrequest),
      .wt_readdata(wt_readdata), .wt_readdatavalid(wt_readdatavalid),
      .out_write(out_write), .out_address(out_address), .out_writedata(out_writedata),
      .out_waitrequest(out_waitrequest),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .outstanding(outstanding), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h100) return 32'hA5A5_A5A5;
      return (a * 32'd3) ^ 32'h5A00_0000;
   endfunction

   task automatic drive_inputs();
      in_read = (in_pend.size() != 0);
      in_address = '0;
      if (in_read) in_address = in_pend[0];
      wt_read = (wt_pend.size() != 0);
      wt_address = '0;
      if (wt_read) wt_address = wt_pend[0];
      out_write = (out_pend.size() != 0);
      out_address = '0;
      out_writedata = '0;
      if (out_write) begin
         out_address = out_pend[0].addr;
         out_writedata = out_pend[0].data;
      end
      m_readdatavalid = 1'b0;
      if (auto_resp && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         m_readdatavalid = 1'b1;
         m_readdata = mem_data(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
      #1;
   endtask

   task automatic step();
      wreq_t w;
      mreq_t r;
      logic [31:0] e;
      if (in_read && !in_waitrequest) begin
         grant_log.push_back(0);
         exp_in_q.push_back(mem_data(in_address));
         void'(in_pend.pop_front());
      end
      if (wt_read && !wt_waitrequest) begin
         grant_log.push_back(1);
         exp_wt_q.push_back(mem_data(wt_address));
         void'(wt_pend.pop_front());
      end
      if (out_write && !out_waitrequest) begin
         grant_log.push_back(2);
         w.addr = out_address;
         w.data = out_writedata;
         exp_wr_q.push_back(w);
         void'(out_pend.pop_front());
      end
      if (rst_n && m_read && !m_waitrequest) begin
         r.due = cyc + LAT;
         r.addr = m_address;
         mem_q.push_back(r);
      end
      if (rst_n && m_write && !m_waitrequest) begin
         n_checks++;
         if (exp_wr_q.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected: got m_write addr=%h, required no write", m_address);
         end else begin
            w = exp_wr_q.pop_front();
            if (m_address !== w.addr || m_writedata !== w.data) begin
               n_err++;
               $display("FAIL write_cmd: got %h/%h, required %h/%h", m_address, m_writedata, w.addr, w.data);
            end
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (in_readdatavalid) begin
         n_in_rdv++;
         n_checks++;
         if (exp_in_q.size() == 0) begin
            n_err++;
            $display("FAIL in_rdv_unexpected: got data %h, required no pulse", in_readdata);
         end else begin
            e = exp_in_q.pop_front();
            if (in_readdata !== e) begin
               n_err++;
               $display("FAIL in_readdata: got %h, required %h", in_readdata, e);
            end
         end
      end
      if (wt_readdatavalid) begin
         n_checks++;
         if (exp_wt_q.size() == 0) begin
            n_err++;
            $display("FAIL wt_rdv_unexpected: got data %h, required no pulse", wt_readdata);
         end else begin
            e = exp_wt_q.pop_front();
            if (wt_readdata !== e) begin
               n_err++;
               $display("FAIL wt_readdata: got %h, required %h", wt_readdata, e);
            end
         end
      end
      drive_inputs();
   endtask

   function automatic int pending();
      return exp_in_q.size() + exp_wt_q.size() + exp_wr_q.size() + mem_q.size()
           + in_pend.size() + wt_pend.size() + out_pend.size();
   endfunction

   task automatic drain(input int bound, input string name);
      int i = 0;
      while (pending() != 0 && i < bound) begin
         step();
         i++;
      end
      step();
      step();
      n_checks++;
      if (pending() != 0) begin
         n_err++;
         $display("FAIL %s_timeout: got %0d items pending after %0d cycles, required 0", name, pending(), bound);
      end
      n_checks++;
      if (outstanding !== 4'd0) begin
         n_err++;
         $display("FAIL %s_outstanding_end: got %0d, required 0", name, outstanding);
      end
   endtask

   task automatic clear_tb();
      in_pend.delete(); wt_pend.delete(); out_pend.delete();
      exp_in_q.delete(); exp_wt_q.delete(); exp_wr_q.delete();
      mem_q.delete(); grant_log.delete();
      auto_resp = 1'b1;
      m_waitrequest = 1'b0;
      m_readdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_tb();
      drive_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_tb();
      in_pend.push_back(32'h40);
      out_pend.push_back('{addr: 32'h44, data: 32'h1});
      drive_inputs();
      #12;
      n_checks++;
      if ({in_waitrequest, wt_waitrequest, out_waitrequest} !== 3'b111) begin
         n_err++;
         $display("FAIL reset_waitrequest: got %b, required 111", {in_waitrequest, wt_waitrequest, out_waitrequest});
      end
      n_checks++;
      if ({m_read, m_write} !== 2'b00 || m_address !== 32'h0 || m_writedata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_m_cmd: got rd=%b wr=%b a=%h d=%h, required 0", m_read, m_write, m_address, m_writedata);
      end
      n_checks++;
      if ({in_readdatavalid, wt_readdatavalid} !== 2'b00 || in_readdata !== 32'h0 || wt_readdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_return: got v=%b%b %h %h, required zeros", in_readdatavalid, wt_readdatavalid, in_readdata, wt_readdata);
      end
      n_checks++;
      if (outstanding !== 4'd0 || err_orphan !== 1'b0) begin
         n_err++;
         $display("FAIL reset_status: got outstanding=%0d err=%b, required 0/0", outstanding, err_orphan);
      end
      do_reset();
   endtask

   task automatic test_single_read();
      do_reset();
      n_in_rdv = 0;
      in_pend.push_back(32'h100);
      drive_inputs();
      n_checks++;
      if (in_waitrequest !== 1'b0) begin
         n_err++;
         $display("FAIL single_accept: got in_waitrequest=%b, required 0", in_waitrequest);
      end
      step();
      n_checks++;
      if (m_read !== 1'b1 || m_address !== 32'h100 || in_waitrequest !== 1'b1) begin
         n_err++;
         $display("FAIL single_issue: got m_read=%b addr=%h wreq=%b, required 1/100/1", m_read, m_address, in_waitrequest);
      end
      step();
      n_checks++;
      if (m_read !== 1'b0 || outstanding !== 4'd1) begin
         n_err++;
         $display("FAIL single_inflight: got m_read=%b outstanding=%0d, required 0/1", m_read, outstanding);
      end
      drain(20, "single");
      n_checks++;
      if (n_in_rdv != 1 || in_readdata !== 32'hA5A5_A5A5) begin
         n_err++;
         $display("FAIL single_return: got %0d pulses data=%h, required 1 pulse A5A5A5A5", n_in_rdv, in_readdata);
      end
   endtask

   task automatic test_round_robin();
      int exp_order[4] = '{0, 1, 0, 1};
      do_reset();
      in_pend.push_back(32'h300); in_pend.push_back(32'h304);
      wt_pend.push_back(32'h400); wt_pend.push_back(32'h404);
      drive_inputs();
      drain(40, "rr");
      n_checks++;
      if (grant_log.size() != 4) begin
         n_err++;
         $display("FAIL rr_grants: got %0d grants, required 4", grant_log.size());
      end
      for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
         n_checks++;
         if (grant_log[i] != exp_order[i]) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got stream %0d, required %0d", i, grant_log[i], exp_order[i]);
         end
      end
   endtask

   task automatic test_write_priority();
      do_reset();
      in_pend.push_back(32'h500);
      wt_pend.push_back(32'h600);
      out_pend.push_back('{addr: 32'h200, data: 32'h1234});
      drive_inputs();
      n_checks++;
      if ({out_waitrequest, in_waitrequest, wt_waitrequest} !== 3'b011) begin
         n_err++;
         $display("FAIL wr_prio_accept: got out/in/wt=%b, required 011", {out_waitrequest, in_waitrequest, wt_waitrequest});
      end
      step();
      n_checks++;
      if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h200 || m_writedata !== 32'h1234) begin
         n_err++;
         $display("FAIL wr_prio_cmd: got wr=%b rd=%b a=%h d=%h, required 1/0/200/1234", m_write, m_read, m_address, m_writedata);
      end
      step();
      n_checks++;
      if (outstanding !== 4'd0 || m_write !== 1'b0) begin
         n_err++;
         $display("FAIL wr_no_tag: got outstanding=%0d m_write=%b, required 0/0", outstanding, m_write);
      end
      drain(40, "wr_prio");
   endtask

   task automatic test_stall();
      do_reset();
      m_waitrequest = 1'b1;
      in_pend.push_back(32'h700);
      wt_pend.push_back(32'h800);
      drive_inputs();
      step();
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (m_read !== 1'b1 || m_address !== 32'h700 || {in_waitrequest, wt_waitrequest} !== 2'b11) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got rd=%b a=%h wreq=%b, required 1/700/11", k, m_read, m_address, {in_waitrequest, wt_waitrequest});
         end
         step();
      end
      n_checks++;
      if (grant_log.size() != 1 || outstanding !== 4'd0) begin
         n_err++;
         $display("FAIL stall_grants: got %0d grants outstanding=%0d, required 1/0", grant_log.size(), outstanding);
      end
      m_waitrequest = 1'b0;
      #1;
      drain(40, "stall");
   endtask

   task automatic test_full();
      int i;
      do_reset();
      auto_resp = 1'b0;
      for (int k = 0; k < 9; k++) in_pend.push_back(32'h1000 + 32'(4 * k));
      drive_inputs();
      i = 0;
      while (grant_log.size() < 8 && i < 40) begin step(); i++; end
      step(); step(); step();
      n_checks++;
      if (grant_log.size() != 8 || outstanding !== 4'd8 || in_read !== 1'b1 || in_waitrequest !== 1'b1) begin
         n_err++;
         $display("FAIL full_stall: got grants=%0d outstanding=%0d wreq=%b, required 8/8/1", grant_log.size(), outstanding, in_waitrequest);
      end
      out_pend.push_back('{addr: 32'h2000, data: 32'hCAFE});
      drive_inputs();
      i = 0;
      while (grant_log.size() < 9 && i < 10) begin step(); i++; end
      step(); step();
      n_checks++;
      if (grant_log.size() != 9 || grant_log[grant_log.size()-1] != 2 || outstanding !== 4'd8) begin
         n_err++;
         $display("FAIL full_write: got grants=%0d outstanding=%0d, required write granted with 8 outstanding", grant_log.size(), outstanding);
      end
      auto_resp = 1'b1;
      i = 0;
      while (grant_log.size() < 10 && i < 20) begin step(); i++; end
      n_checks++;
      if (grant_log.size() != 10 || grant_log[grant_log.size()-1] != 0) begin
         n_err++;
         $display("FAIL full_release: got %0d grants, required 10 ending with input read", grant_log.size());
      end
      drain(60, "full");
   endtask

   task automatic test_orphan_and_reset();
      do_reset();
      m_readdata = 32'hDEAD_BEEF;
      m_readdatavalid = 1'b1;
      #1;
      step();
      n_checks++;
      if (err_orphan !== 1'b1 || {in_readdatavalid, wt_readdatavalid} !== 2'b00 || outstanding !== 4'd0) begin
         n_err++;
         $display("FAIL orphan: got err=%b rdv=%b%b outstanding=%0d, required 1/00/0", err_orphan, in_readdatavalid, wt_readdatavalid, outstanding);
      end
      step();
      n_checks++;
      if (err_orphan !== 1'b1) begin
         n_err++;
         $display("FAIL orphan_sticky: got err=%b, required 1", err_orphan);
      end
      m_waitrequest = 1'b1;
      in_pend.push_back(32'h900);
      drive_inputs();
      step();
      n_checks++;
      if (m_read !== 1'b1 || m_address !== 32'h900) begin
         n_err++;
         $display("FAIL midissue_pre: got rd=%b a=%h, required 1/900", m_read, m_address);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (m_read !== 1'b0 || m_address !== 32'h0 || in_waitrequest !== 1'b1 || err_orphan !== 1'b0 || outstanding !== 4'd0) begin
         n_err++;
         $display("FAIL midissue_reset: got rd=%b a=%h wreq=%b err=%b out=%0d, required 0/0/1/0/0", m_read, m_address, in_waitrequest, err_orphan, outstanding);
      end
      clear_tb();
      drive_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      m_readdata = 32'h0BAD_0BAD;
      m_readdatavalid = 1'b1;
      #1;
      step();
      n_checks++;
      if (err_orphan !== 1'b1 || {in_readdatavalid, wt_readdatavalid} !== 2'b00) begin
         n_err++;
         $display("FAIL late_data: got err=%b rdv=%b%b, required 1/00", err_orphan, in_readdatavalid, wt_readdatavalid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running at 200us, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_priority();
      test_stall();
      test_full();
      test_orphan_and_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
